mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit. Takes EX/MEM signals, runs a req/gnt/rvalid transaction on the data-memory bus,
//  aligns and extends load data, and drives the mem_* inputs of the MEM/WB register. Stalls the pipeline
//  (mem_stall) while a transaction is outstanding; presents mem_regwrite=0 whenever no valid writeback exists.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+RESP before abort with mem_bus_err; 8-bit counter, legal range 1..255.
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   synchronous, active-high reset
//  ex_valid        in   1   EX/MEM holds a real instruction
//  ex_alu_result   in   32  effective address / ALU result
//  ex_rs2_data     in   32  store data
//  ex_rd           in   5   destination register
//  ex_funct3       in   3   access size/sign (RV32I encoding)
//  ex_memread      in   1   load
//  ex_memwrite     in   1   store
//  ex_regwrite     in   1   writes rd
//  ex_memtoreg     in   1   WB selects memory data
//  dmem_req        out  1   bus request, held until dmem_gnt
//  dmem_we         out  1   1=store
//  dmem_addr       out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata      out  32  store data replicated into lanes
//  dmem_be         out  4   byte enables
//  dmem_gnt        in   1   request accepted this cycle
//  dmem_rvalid     in   1   load data valid
//  dmem_rdata      in   32  load word
//  mem_mem_data    out  32  aligned/extended load data
//  mem_alu_result  out  32  pass-through of ex_alu_result
//  mem_rd          out  5   pass-through of ex_rd
//  mem_regwrite    out  1   valid writeback this cycle
//  mem_memtoreg    out  1   pass-through of ex_memtoreg
//  mem_stall       out  1   freeze IF..EX/MEM this cycle
//  mem_misalign    out  1   1-cycle pulse: misaligned access dropped
//  mem_bus_err     out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  - States IDLE, REQ, RESP, DONE. Reset: state=IDLE, dmem_req/we=0, be=0, addr/wdata=0, captured data=0,
//    counter=0, pulses=0. Reset mid-transaction abandons it; rvalid arriving later is ignored (not in RESP).
//  - mem_op = ex_valid & (ex_memread|ex_memwrite). Non-mem instructions: IDLE, combinational pass-through,
//    mem_regwrite = ex_valid & ex_regwrite, mem_mem_data=0, mem_stall=0.
//  - Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus traffic, mem_misalign=1, mem_regwrite=0, no stall.
//  - IDLE & aligned mem_op: mem_stall=1, registered dmem_* loaded, ->REQ. REQ: dmem_req=1; on gnt: store->DONE,
//    load->RESP; dmem_req drops the cycle after gnt. RESP: on rvalid capture aligned data ->DONE; rvalid in same
//    cycle as gnt is not legal bus behaviour and is ignored.
//  - DONE (1 cycle): mem_stall=0, mem_regwrite=ex_regwrite (0 for stores), mem_mem_data=captured; ->IDLE.
//  - mem_stall=1 in IDLE(aligned mem_op), REQ, RESP. Upstream holds ex_* stable while stalled.
//  - Latency, zero-wait bus (gnt 1st REQ cycle, rvalid next): load 4 cycles IDLE,REQ,RESP,DONE; store 3.
//  - Counter clears on entering REQ, increments in REQ/RESP; reaching TIMEOUT_CYCLES: dmem_req=0, mem_bus_err=1,
//    ->DONE with mem_regwrite forced 0.
//  - Stores: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111.
//  - Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is; loads use be=1111.
//  - Unsupported funct3 on a mem_op is treated as misaligned (dropped, mem_misalign=1).
// STRUCTURE
//  - rv32i_pkg: funct3 constants (F3_B/H/W/BU/HU), LSU state encodings, TIMEOUT counter width.
//  - Sub-module load_align_ext (combinational): rdata, addr[1:0], funct3 -> 32-bit extended load value.
// TESTING
//  - LW addr 0x100, rdata 0xDEADBEEF, zero-wait -> stall 3 cycles, DONE: mem_mem_data=0xDEADBEEF, mem_regwrite=1.
//  - LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  - SB addr 0x101, rs2=0x000000AB -> be=0010, wdata=0xABABABAB, dmem_we=1, mem_regwrite=0 in DONE.
//  - SW addr 0x102 -> mem_misalign pulse, no dmem_req, no stall, mem_regwrite=0.
//  - gnt withheld 255 cycles -> mem_bus_err pulse, mem_regwrite=0, IDLE; then ADD passes through unstalled.
//  - rst in RESP, rvalid 2 cycles later -> ignored; dmem_req=0, mem_stall=0, outputs at reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: funct3 encodings, LSU state encoding and access legality helper
package rv32i_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} lsu_state_t;
  function automatic logic lsu_bad(input logic [2:0] f3, input logic [1:0] a, input logic st);
    return (f3 == F3_B)  ? 1'b0 :
           (f3 == F3_H)  ? a[0] :
           (f3 == F3_W)  ? |a :
           (f3 == F3_BU) ? st :
           (f3 == F3_HU) ? (st | a[0]) : 1'b1;
  endfunction
endpackage

// File: rtl/mem_stage_lsu_load_align_ext.sv
// load_align_ext: picks the addressed byte/half of a load word and extends it
module load_align_ext
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select followed by sign/zero extension
  always_comb begin
    b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16]) : (addr[0] ? rdata[15:8] : rdata[7:0]);
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
           (funct3 == F3_BU) ? {24'd0, b} :
           (funct3 == F3_H)  ? {{16{h[15]}}, h} :
           (funct3 == F3_HU) ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/gnt/rvalid data bus
module mem_stage_lsu
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_mem_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_rd,
  output logic        mem_regwrite,
  output logic        mem_memtoreg,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_bus_err
);
  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_q, ld_data, st_wdata;
  logic [3:0]       st_be;
  logic             err_q, mem_op, bad, idle, go, tmo;
  load_align_ext u_align (
    .rdata  (dmem_rdata),
    .addr   (ex_alu_result[1:0]),
    .funct3 (ex_funct3),
    .data   (ld_data)
  );
  // access decode and bus lane formatting for the instruction held in EX/MEM
  always_comb begin
    mem_op   = ex_valid & (ex_memread | ex_memwrite);
    bad      = lsu_bad(ex_funct3, ex_alu_result[1:0], ex_memwrite);
    idle     = state == S_IDLE;
    go       = idle & mem_op & ~bad;
    tmo      = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    st_be    = ~ex_memwrite ? 4'hF :
               (ex_funct3 == F3_B) ? 4'b0001 << ex_alu_result[1:0] :
               (ex_funct3 == F3_H) ? (ex_alu_result[1] ? 4'b1100 : 4'b0011) : 4'hF;
    st_wdata = (ex_funct3 == F3_B) ? {4{ex_rs2_data[7:0]}} :
               (ex_funct3 == F3_H) ? {2{ex_rs2_data[15:0]}} : ex_rs2_data;
  end
  // MEM/WB-facing outputs; timeouts and stores never write back
  always_comb begin
    mem_alu_result = ex_alu_result;
    mem_rd         = ex_rd;
    mem_memtoreg   = ex_memtoreg;
    mem_mem_data   = (state == S_DONE) ? data_q : 32'd0;
    mem_regwrite   = (state == S_DONE) ? ex_valid & ex_regwrite & ~dmem_we & ~err_q :
                     idle & ex_valid & ~mem_op & ex_regwrite;
    mem_stall      = go | state == S_REQ | state == S_RESP;
    mem_misalign   = idle & mem_op & bad;
    mem_bus_err    = err_q;
  end
  // bus transaction FSM with a shared REQ+RESP timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      data_q     <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state      <= S_REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= ex_memwrite;
          dmem_addr  <= {ex_alu_result[31:2], 2'b00};
          dmem_wdata <= st_wdata;
          dmem_be    <= st_be;
          cnt        <= '0;
          err_q      <= 1'b0;
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem_gnt | tmo) begin
            dmem_req <= 1'b0;
            err_q    <= ~dmem_gnt;
            state    <= (dmem_gnt & ~dmem_we) ? S_RESP : S_DONE;
          end
        end
        S_RESP: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem_rvalid) data_q <= ld_data;
          if (dmem_rvalid | tmo) begin
            err_q <= ~dmem_rvalid;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
